// File: rtl/ccip_c0_rd_line_scheduler_if.sv
// Request/issue/response bundle between the AFU read engines, the line scheduler
// and the c0 Tx request formatter.
interface ccip_c0_rd_line_scheduler_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned CNT_W = 10
);
  logic [N_REQ-1:0]   req_valid;
  logic [2*N_REQ-1:0] req_len;
  logic [N_REQ-1:0]   req_ready;
  logic               c0TxAlmFull;
  logic               issue_valid;
  logic [1:0]         issue_len;
  logic [2:0]         issue_src;
  logic               rsp_line_valid;
  logic               drain_req;
  logic               drain_done;
  logic [CNT_W-1:0]   active_lines;
  logic [1:0]         err_sticky;

  modport master (
    output req_valid, req_len, c0TxAlmFull, rsp_line_valid, drain_req,
    input  req_ready, issue_valid, issue_len, issue_src, drain_done, active_lines, err_sticky
  );

  modport slave (
    input  req_valid, req_len, c0TxAlmFull, rsp_line_valid, drain_req,
    output req_ready, issue_valid, issue_len, issue_src, drain_done, active_lines, err_sticky
  );
endinterface

// File: rtl/ccip_c0_rd_line_scheduler.sv
// Round-robin arbiter for the CCI-P c0 read-request channel that bounds the number of
// outstanding lines, rejects unsupported lengths and offers a drain handshake.
module ccip_c0_rd_line_scheduler #(
  parameter int unsigned N_REQ            = 2,
  parameter int unsigned MAX_ACTIVE_LINES = 512,
  parameter logic [3:0]  CL_LEN_SUPPORTED = 4'hB,
  parameter int unsigned CNT_W            = $clog2(MAX_ACTIVE_LINES + 1)
) (
  input logic                           clk,
  input logic                           reset,
  ccip_c0_rd_line_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {StRun, StDrain, StDrained} state_e;

  localparam logic [CNT_W:0] MaxLines = (CNT_W + 1)'(MAX_ACTIVE_LINES);

  state_e           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_valid_q, issue_valid_d;
  logic [1:0]       issue_len_q, issue_len_d;
  logic [2:0]       issue_src_q, issue_src_d;
  logic [1:0]       err_q, err_d;

  logic [N_REQ-1:0] elig, grant;
  logic             found, illegal_seen, rsp_ok;
  logic [2:0]       win_idx;
  logic [1:0]       win_len;
  logic [2:0]       grant_lines;

  function automatic logic [2:0] nlines(input logic [1:0] len);
    case (len)
      2'd0:    nlines = 3'd1;
      2'd1:    nlines = 3'd2;
      2'd3:    nlines = 3'd4;
      default: nlines = 3'd0;
    endcase
  endfunction

  function automatic logic len_legal(input logic [1:0] len);
    len_legal = (len != 2'd2) && CL_LEN_SUPPORTED[len];
  endfunction

  always_comb begin
    elig         = '0;
    illegal_seen = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      logic [1:0] len;
      len = bus.req_len[2*i +: 2];
      if (bus.req_valid[i] && !len_legal(len)) illegal_seen = 1'b1;
      // Reset gates eligibility so req_ready drops the instant reset asserts.
      elig[i] = bus.req_valid[i] && len_legal(len) && (state_q == StRun) && !bus.c0TxAlmFull &&
                !reset && (({1'b0, cnt_q} + (CNT_W + 1)'(nlines(len))) <= MaxLines);
    end

    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = 3'(idx);
      end
    end

    win_len     = bus.req_len[2*win_idx +: 2];
    grant_lines = found ? nlines(win_len) : 3'd0;

    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (int'(win_idx) + 1 >= int'(N_REQ)) ? 3'd0 : win_idx + 3'd1;

    issue_valid_d = found;
    issue_len_d   = found ? win_len : 2'd0;
    issue_src_d   = found ? win_idx : 3'd0;

    // A response with nothing outstanding and no concurrent grant would underflow.
    rsp_ok = bus.rsp_line_valid && ((cnt_q != '0) || found);
    cnt_d  = CNT_W'(({1'b0, cnt_q} + (CNT_W + 1)'(grant_lines)) - (CNT_W + 1)'(rsp_ok));
    err_d  = err_q | {bus.rsp_line_valid && !rsp_ok, illegal_seen};

    state_d = state_q;
    unique case (state_q)
      StRun:     if (bus.drain_req) state_d = StDrain;
      StDrain: begin
        if (!bus.drain_req)                       state_d = StRun;
        else if ((cnt_d == '0) && !issue_valid_q) state_d = StDrained;
      end
      StDrained: if (!bus.drain_req) state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_len_q   <= '0;
      issue_src_q   <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      issue_valid_q <= issue_valid_d;
      issue_len_q   <= issue_len_d;
      issue_src_q   <= issue_src_d;
      err_q         <= err_d;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_len    = issue_len_q;
  assign bus.issue_src    = issue_src_q;
  assign bus.drain_done   = (state_q == StDrained);
  assign bus.active_lines = cnt_q;
  assign bus.err_sticky   = err_q;

endmodule

// File: tb/tb_ccip_c0_rd_line_scheduler.sv
// Directed bench: dut_a (512-line ceiling) covers round-robin alternation, dut_b (8-line
// ceiling) covers throttling, netting, illegal length, drain, almost-full and reset.
module tb_ccip_c0_rd_line_scheduler;

  localparam int unsigned CntWA = $clog2(512 + 1);
  localparam int unsigned CntWB = $clog2(8 + 1);

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  ccip_c0_rd_line_scheduler_if #(.N_REQ(2), .CNT_W(CntWA)) bus_a ();
  ccip_c0_rd_line_scheduler_if #(.N_REQ(2), .CNT_W(CntWB)) bus_b ();

  ccip_c0_rd_line_scheduler #(.N_REQ(2), .MAX_ACTIVE_LINES(512)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  ccip_c0_rd_line_scheduler #(.N_REQ(2), .MAX_ACTIVE_LINES(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and registered outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.req_valid = '0; bus_a.req_len = '0; bus_a.c0TxAlmFull = 1'b0;
    bus_a.rsp_line_valid = 1'b0; bus_a.drain_req = 1'b0;
    bus_b.req_valid = '0; bus_b.req_len = '0; bus_b.c0TxAlmFull = 1'b0;
    bus_b.rsp_line_valid = 1'b0; bus_b.drain_req = 1'b0;
    #12;
    check_eq("rst_outs_a", {bus_a.req_ready, bus_a.issue_valid, bus_a.issue_len, bus_a.issue_src,
                            bus_a.drain_done, 6'(bus_a.active_lines), bus_a.err_sticky}, 0);
    check_eq("rst_outs_b", {bus_b.req_ready, bus_b.issue_valid, bus_b.issue_len, bus_b.issue_src,
                            bus_b.drain_done, 6'(bus_b.active_lines), bus_b.err_sticky}, 0);
    step();
    reset = 1'b0;

    // Test 1: both requesters, len 0, alternate grants; issue follows one cycle later.
    bus_a.req_valid = 2'b11;
    bus_a.req_len   = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("t1_ready", bus_a.req_ready, 32'(1 << (c % 2)));
      step();
      check_eq("t1_issue_valid", bus_a.issue_valid, 1);
      check_eq("t1_issue_src", bus_a.issue_src, 32'(c % 2));
    end
    bus_a.req_valid = '0;
    check_eq("t1_active", bus_a.active_lines, 4);

    // Test 2: req0 len 3 against an 8-line ceiling.
    bus_b.req_valid = 2'b01;
    bus_b.req_len   = 4'b0011;
    #1;
    check_eq("t2_ready0", bus_b.req_ready, 2'b01);
    step();
    check_eq("t2_active4", bus_b.active_lines, 4);
    check_eq("t2_issue_len", bus_b.issue_len, 3);
    check_eq("t2_ready1", bus_b.req_ready, 2'b01);
    step();
    check_eq("t2_active8", bus_b.active_lines, 8);
    check_eq("t2_full_ready", bus_b.req_ready, 2'b00);
    bus_b.rsp_line_valid = 1'b1;
    step();
    check_eq("t2_active7", bus_b.active_lines, 7);
    check_eq("t2_one_rsp_ready", bus_b.req_ready, 2'b00);
    repeat (3) step();
    bus_b.rsp_line_valid = 1'b0;
    #1;
    check_eq("t2_active4b", bus_b.active_lines, 4);
    check_eq("t2_regrant", bus_b.req_ready, 2'b01);
    bus_b.req_valid = '0;

    // Test 3: one len-0 grant to reach 5, then len-1 grant netting with a response.
    bus_b.req_valid = 2'b10;
    bus_b.req_len   = 4'b0000;
    step();
    check_eq("t3_active5", bus_b.active_lines, 5);
    bus_b.req_len        = 4'b0100;
    bus_b.rsp_line_valid = 1'b1;
    #1;
    check_eq("t3_ready", bus_b.req_ready, 2'b10);
    step();
    bus_b.req_valid      = '0;
    bus_b.rsp_line_valid = 1'b0;
    check_eq("t3_active6", bus_b.active_lines, 6);

    // Test 4: req0 illegal clLen 2 never wins; req1 granted every cycle.
    bus_b.req_valid      = 2'b11;
    bus_b.req_len        = 4'b0010;
    bus_b.rsp_line_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("t4_ready", bus_b.req_ready, 2'b10);
      step();
    end
    bus_b.req_valid      = '0;
    bus_b.rsp_line_valid = 1'b0;
    check_eq("t4_err0", bus_b.err_sticky, 2'b01);
    check_eq("t4_src", bus_b.issue_src, 1);
    check_eq("t4_active", bus_b.active_lines, 6);

    // Test 5: bring count to 3, drain, then resume.
    bus_b.rsp_line_valid = 1'b1;
    repeat (3) step();
    bus_b.rsp_line_valid = 1'b0;
    check_eq("t5_active3", bus_b.active_lines, 3);
    bus_b.drain_req = 1'b1;
    step();
    bus_b.req_valid = 2'b01;
    bus_b.req_len   = 4'b0000;
    #1;
    check_eq("t5_drain_ready", bus_b.req_ready, 2'b00);
    check_eq("t5_done_early", bus_b.drain_done, 0);
    bus_b.rsp_line_valid = 1'b1;
    step();
    step();
    check_eq("t5_done_before_last", bus_b.drain_done, 0);
    step();
    bus_b.rsp_line_valid = 1'b0;
    check_eq("t5_done", bus_b.drain_done, 1);
    check_eq("t5_active0", bus_b.active_lines, 0);
    check_eq("t5_drained_ready", bus_b.req_ready, 2'b00);
    bus_b.drain_req = 1'b0;
    step();
    check_eq("t5_done_clear", bus_b.drain_done, 0);
    check_eq("t5_resume_ready", bus_b.req_ready, 2'b01);
    step();
    bus_b.req_valid = '0;
    check_eq("t5_active1", bus_b.active_lines, 1);

    // Test 6: almost-full blocks grants; underflow sets sticky bit; async reset clears all.
    bus_b.c0TxAlmFull = 1'b1;
    bus_b.req_valid   = 2'b11;
    #1;
    check_eq("t6_almfull_ready", bus_b.req_ready, 2'b00);
    bus_b.rsp_line_valid = 1'b1;
    step();
    check_eq("t6_active0", bus_b.active_lines, 0);
    step();
    bus_b.rsp_line_valid = 1'b0;
    check_eq("t6_underflow_cnt", bus_b.active_lines, 0);
    check_eq("t6_err", bus_b.err_sticky, 2'b11);
    bus_b.c0TxAlmFull = 1'b0;
    step();
    check_eq("t6_traffic", bus_b.issue_valid, 1);
    reset = 1'b1;
    #1;
    check_eq("t6_reset_outs", {bus_b.req_ready, bus_b.issue_valid, bus_b.issue_len,
                               bus_b.issue_src, bus_b.drain_done, 6'(bus_b.active_lines),
                               bus_b.err_sticky}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
